// File: rtl/sha1_result_writer_if.sv
// rtl/sha1_result_writer_if.sv - word store bus between the digest writer and data memory
interface sha1_result_writer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;

  modport master (output req, output we, output addr, output data, input ack);
  modport slave  (input req, input we, input addr, input data, output ack);
endinterface

// File: rtl/sha1_result_writer.sv
// rtl/sha1_result_writer.sv - stores a captured SHA-1 digest as consecutive 32-bit words,
// with one pending digest slot, overflow/misalignment/timeout error reporting
module sha1_result_writer #(
  parameter int WORDS       = 5,
  parameter int ADDR_STEP   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*WORDS-1:0]   result,
  input  logic                  ready,
  input  logic [31:0]           addr,
  sha1_result_writer_if.master  mem,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int DW = 32 * WORDS;
  localparam int IW = $clog2(WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] active, pend_data;
  logic [31:0]   base, pend_addr;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          timed_out, timed_out_n;
  logic          pend_valid;
  logic          load_in, load_pend, pend_set, pend_clr;
  logic          consumed, mis, ovf, tmo, aligned;
  logic          err_n;
  logic [1:0]    err_code_n;
  logic [31:0]   word;

  assign aligned = (addr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active     <= '0;
      base       <= '0;
      idx        <= '0;
      tcnt       <= '0;
      timed_out  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_addr  <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tcnt      <= tcnt_n;
      timed_out <= timed_out_n;
      err       <= err_n;
      err_code  <= err_code_n;
      if (load_in) begin
        active <= result;
        base   <= addr;
      end else if (load_pend) begin
        active <= pend_data;
        base   <= pend_addr;
      end
      if (pend_set) begin
        pend_data  <= result;
        pend_addr  <= addr;
        pend_valid <= 1'b1;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    tcnt_n      = tcnt;
    timed_out_n = timed_out;
    load_in     = 1'b0;
    load_pend   = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    consumed    = 1'b0;
    mis         = 1'b0;
    ovf         = 1'b0;
    tmo         = 1'b0;
    err_n       = 1'b0;
    err_code_n  = 2'b00;
    case (state)
      IDLE: begin
        if (ready) begin
          consumed = 1'b1;
          if (aligned) begin
            load_in = 1'b1;
            idx_n   = '0;
            tcnt_n  = '0;
            state_n = REQ;
          end else begin
            mis = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.ack) begin
          tcnt_n = '0;
          if (idx == IW'(WORDS - 1)) begin
            timed_out_n = 1'b0;
            state_n     = DONE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          // Remaining words are abandoned; DONE still runs so a pending digest gets served.
          tmo         = 1'b1;
          tcnt_n      = '0;
          timed_out_n = 1'b1;
          state_n     = DONE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      DONE: begin
        idx_n       = '0;
        tcnt_n      = '0;
        timed_out_n = 1'b0;
        if (pend_valid) begin
          load_pend = 1'b1;
          pend_clr  = 1'b1;
          state_n   = REQ;
        end else if (ready && aligned) begin
          load_in  = 1'b1;
          consumed = 1'b1;
          state_n  = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (ready && !consumed) begin
      if (!aligned)        mis      = 1'b1;
      else if (!pend_valid) pend_set = 1'b1;
      else                  ovf      = 1'b1;
    end

    if (tmo) begin
      err_n      = 1'b1;
      err_code_n = 2'b11;
    end else if (ovf) begin
      err_n      = 1'b1;
      err_code_n = 2'b10;
    end else if (mis) begin
      err_n      = 1'b1;
      err_code_n = 2'b01;
    end
  end

  // H0 sits in the top bits, so word 0 is the most significant slice.
  always_comb begin
    word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) word = active[DW-1-32*w -: 32];
    end
  end

  assign mem.req  = (state == REQ);
  assign mem.we   = (state == REQ);
  assign mem.addr = (state == REQ) ? base + 32'(idx) * 32'(ADDR_STEP) : 32'h0;
  assign mem.data = (state == REQ) ? word : 32'h0;
  assign done     = (state == DONE) && !timed_out;
  assign busy     = (state != IDLE) || pend_valid;
endmodule

// File: tb/tb_sha1_result_writer.sv
// tb/tb_sha1_result_writer.sv - directed bench for sha1_result_writer
module tb_sha1_result_writer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [159:0] result = '0;
  logic         ready = 1'b0;
  logic [31:0]  addr = '0;
  logic         busy, done, err;
  logic [1:0]   err_code;

  sha1_result_writer_if mem();

  sha1_result_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .result   (result),
    .ready    (ready),
    .addr     (addr),
    .mem      (mem.master),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [159:0] D1 = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] D2 = 160'h00112233_44556677_8899AABB_CCDDEEFF_0F1E2D3C;
  localparam logic [159:0] D3 = 160'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE_13579BDF;

  int tests = 0;
  int fails = 0;

  int          ack_mode = 0;
  int          hold = 0;
  int          req_cycles = 0;
  int          wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cyc[$];
  int          err_cyc[$];
  logic [1:0]  err_c[$];

  // ack for the coming edge, plus logging of accepted words and status pulses
  always @(negedge clk) begin
    if (ack_mode == 1) begin
      if (mem.req) begin
        mem.ack = (hold == 3);
        hold = (hold == 3) ? 0 : hold + 1;
      end else begin
        mem.ack = 1'b0;
      end
    end else begin
      mem.ack = (ack_mode == 0);
    end
    if (mem.req) req_cycles++;
    if (mem.req && mem.ack) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem.addr);
      wr_data.push_back(mem.data);
    end
    if (done) done_cyc.push_back(cyc);
    if (err) begin
      err_cyc.push_back(cyc);
      err_c.push_back(err_code);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cyc.delete();
    err_cyc.delete();
    err_c.delete();
    req_cycles = 0;
    hold = 0;
  endtask

  task automatic pulse(input logic [159:0] d, input logic [31:0] a);
    result = d;
    addr   = a;
    ready  = 1'b1;
    @(negedge clk);
    ready  = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_store(input string tag, input int start, input logic [31:0] base,
                             input logic [159:0] d, input int first, input int step);
    for (int i = 0; i < 5; i++) begin
      if (start + i < wr_addr.size()) begin
        check({tag, "_addr"}, wr_addr[start+i], base + 32'(4 * i));
        check({tag, "_data"}, wr_data[start+i], d[159-32*i -: 32]);
        check({tag, "_cyc"}, 32'(wr_cyc[start+i]), 32'(first + step * i));
      end else begin
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(start + i + 1));
      end
    end
  endtask

  int n;

  initial begin
    mem.ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem.req), 0);
    check("rst_we", 32'(mem.we), 0);
    check("rst_addr", mem.addr, 0);
    check("rst_data", mem.data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", {29'd0, err, err_code}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ack held high, best-case latency
    ack_mode = 0;
    clear_logs();
    n = cyc;
    pulse(D1, 32'h1000);
    wait_until(n + 10);
    check("t1_nwr", 32'(wr_addr.size()), 5);
    check_store("t1", 0, 32'h1000, D1, n + 1, 1);
    check("t1_ndone", 32'(done_cyc.size()), 1);
    check("t1_done_cyc", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'(n + 6));
    check("t1_nerr", 32'(err_cyc.size()), 0);
    check("t1_busy", 32'(busy), 0);

    // 2: ack after 3 wait cycles per word
    ack_mode = 1;
    clear_logs();
    n = cyc;
    pulse(D2, 32'h3000);
    wait_until(n + 25);
    check("t2_nwr", 32'(wr_addr.size()), 5);
    check_store("t2", 0, 32'h3000, D2, n + 4, 4);
    check("t2_req_cycles", 32'(req_cycles), 20);
    check("t2_done_cyc", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'(n + 21));

    // 3: pending digest during a store, then overflow
    ack_mode = 0;
    clear_logs();
    n = cyc;
    pulse(D1, 32'h1000);
    wait_until(n + 3);
    pulse(D2, 32'h2000);
    pulse(D3, 32'h5000);
    wait_until(n + 12);
    check("t3_busy_last", 32'(busy), 1);
    wait_until(n + 13);
    check("t3_busy_idle", 32'(busy), 0);
    wait_until(n + 16);
    check("t3_nwr", 32'(wr_addr.size()), 10);
    check_store("t3a", 0, 32'h1000, D1, n + 1, 1);
    check_store("t3b", 5, 32'h2000, D2, n + 7, 1);
    check("t3_ndone", 32'(done_cyc.size()), 2);
    check("t3_done0", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'(n + 6));
    check("t3_done1", 32'(done_cyc.size() > 1 ? done_cyc[1] : -1), 32'(n + 12));
    check("t3_nerr", 32'(err_cyc.size()), 1);
    check("t3_err_cyc", 32'(err_cyc.size() > 0 ? err_cyc[0] : -1), 32'(n + 5));
    check("t3_err_code", 32'(err_c.size() > 0 ? err_c[0] : 2'b00), 32'h2);

    // 4: misaligned address
    clear_logs();
    n = cyc;
    pulse(D1, 32'h1002);
    wait_until(n + 8);
    check("t4_req_cycles", 32'(req_cycles), 0);
    check("t4_nerr", 32'(err_cyc.size()), 1);
    check("t4_err_cyc", 32'(err_cyc.size() > 0 ? err_cyc[0] : -1), 32'(n + 1));
    check("t4_err_code", 32'(err_c.size() > 0 ? err_c[0] : 2'b00), 32'h1);
    check("t4_busy", 32'(busy), 0);
    check("t4_ndone", 32'(done_cyc.size()), 0);

    // 5: ack stuck low -> timeout
    ack_mode = 2;
    clear_logs();
    n = cyc;
    pulse(D1, 32'h4000);
    wait_until(n + 64);
    check("t5_req_last", 32'(mem.req), 1);
    wait_until(n + 65);
    check("t5_req_drop", 32'(mem.req), 0);
    wait_until(n + 66);
    check("t5_busy", 32'(busy), 0);
    wait_until(n + 70);
    check("t5_req_cycles", 32'(req_cycles), 64);
    check("t5_ndone", 32'(done_cyc.size()), 0);
    check("t5_nerr", 32'(err_cyc.size()), 1);
    check("t5_err_cyc", 32'(err_cyc.size() > 0 ? err_cyc[0] : -1), 32'(n + 65));
    check("t5_err_code", 32'(err_c.size() > 0 ? err_c[0] : 2'b00), 32'h3);
    check("t5_nwr", 32'(wr_addr.size()), 0);

    // 6: async reset during word 3, then a clean store
    ack_mode = 0;
    clear_logs();
    n = cyc;
    pulse(D1, 32'h1000);
    wait_until(n + 4);
    check("t6_pre_addr", mem.addr, 32'h100C);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(mem.req), 0);
    check("t6_rst_addr", mem.addr, 0);
    check("t6_rst_data", mem.data, 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    n = cyc;
    pulse(D2, 32'h6000);
    wait_until(n + 10);
    check("t6_nwr", 32'(wr_addr.size()), 5);
    check_store("t6", 0, 32'h6000, D2, n + 1, 1);
    check("t6_ndone", 32'(done_cyc.size()), 1);
    check("t6_nerr", 32'(err_cyc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
